// File: rtl/bcd_7seg_scan.sv
// Three-digit multiplexed seven-segment driver: holds a loaded BCD triple and scans it
// ones -> tens -> hundreds with a dark gap at the start of every digit slot.
module bcd_7seg_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] ones_i,
  input  logic [3:0] tens_i,
  input  logic [1:0] hundreds_i,
  input  logic       blank_lz_i,
  output logic [6:0] seg_o,
  output logic [2:0] an_o
);

  localparam int            CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [6:0]    SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0]    AN_OFF  = (AN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    h_q, h_d, t_q, t_d, o_q, o_d;
  logic          lz_q, lz_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic [3:0]    digit;
  logic [2:0]    onehot;
  logic          gap;
  logic          slot_blank;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h79;
    endcase
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    h_d    = h_q;
    t_d    = t_q;
    o_d    = o_q;
    lz_d   = lz_q;
    seg_d  = SEG_OFF;
    an_d   = AN_OFF;
    digit  = o_q;
    onehot = 3'b001;

    if (load_i) begin
      h_d  = {2'b00, hundreds_i};
      t_d  = tens_i;
      o_d  = ones_i;
      lz_d = blank_lz_i;
    end

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (idx_q)
      2'd1:    begin digit = t_q; onehot = 3'b010; end
      2'd2:    begin digit = h_q; onehot = 3'b100; end
      default: begin digit = o_q; onehot = 3'b001; end
    endcase

    // A blanked leading zero reuses the gap path so slot timing stays identical.
    gap        = (32'(cnt_q) < 32'(BLANK_CYCLES));
    slot_blank = gap || (lz_q && (((idx_q == 2'd2) && (h_q == 4'd0)) ||
                                  ((idx_q == 2'd1) && (h_q == 4'd0) && (t_q == 4'd0))));

    if (!slot_blank) begin
      seg_d = glyph(digit) ^ SEG_OFF;
      an_d  = onehot ^ AN_OFF;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      h_q   <= 4'd0;
      t_q   <= 4'd0;
      o_q   <= 4'd0;
      lz_q  <= 1'b0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      h_q   <= h_d;
      t_q   <= t_d;
      o_q   <= o_d;
      lz_q  <= lz_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Randomized bench for bcd_7seg_scan: every post-reset cycle is compared with a model
// that derives slot position from the edge count since reset release.
module tb_bcd_7seg_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       load_i = 1'b0;
  logic [3:0] ones_i = 4'd0;
  logic [3:0] tens_i = 4'd0;
  logic [1:0] hundreds_i = 2'd0;
  logic       blank_lz_i = 1'b0;
  logic [6:0] seg_o;
  logic [2:0] an_o;

  int vectors = 0;
  int miscompares = 0;

  int         edge_cnt = 0;
  logic [3:0] m_h = 4'd0, m_t = 4'd0, m_o = 4'd0;
  logic       m_lz = 1'b0;
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

  bcd_7seg_scan #(
    .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i), .ones_i(ones_i), .tens_i(tens_i),
    .hundreds_i(hundreds_i), .blank_lz_i(blank_lz_i), .seg_o(seg_o), .an_o(an_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t edge=%0d got=%h expected=%h", tag, $time, edge_cnt, got, exp);
    end
  endtask

  // Output visible after edge k reflects the counter state that existed before that edge.
  task automatic model_out(input int k, output logic [6:0] es, output logic [2:0] ea);
    int c;
    int i;
    logic [3:0] d;
    logic blank;
    c = (k - 1) % SD;
    i = ((k - 1) / SD) % 3;
    d = (i == 0) ? m_o : ((i == 1) ? m_t : m_h);
    blank = (c < BC) || (m_lz && (((i == 2) && (m_h == 0)) ||
                                  ((i == 1) && (m_h == 0) && (m_t == 0))));
    es = blank ? 7'h7F : ~glyph_tab[d];
    ea = blank ? 3'b111 : ~(3'b001 << i);
  endtask

  task automatic step();
    logic [6:0] es;
    logic [2:0] ea;
    @(posedge clk_i);
    edge_cnt++;
    model_out(edge_cnt, es, ea);
    if (load_i) begin
      m_h  = {2'b00, hundreds_i};
      m_t  = tens_i;
      m_o  = ones_i;
      m_lz = blank_lz_i;
    end
    #1;
    $display("edge %0d load=%0b h=%0d t=%0d o=%0d lz=%0b -> seg=%h an=%b", edge_cnt, load_i,
             hundreds_i, tens_i, ones_i, blank_lz_i, seg_o, an_o);
    check("seg", 16'(seg_o), 16'(es));
    check("an", 16'(an_o), 16'(ea));
    load_i = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                         input logic lz);
    hundreds_i = h; tens_i = t; ones_i = o; blank_lz_i = lz; load_i = 1'b1;
    step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    edge_cnt = 0;
    m_h = 0; m_t = 0; m_o = 0; m_lz = 0;
    run(2);
    check("rst_gap_an", 16'(an_o), 16'h7);
    step();
    check("rst_first_an", 16'(an_o), 16'h6);
    check("rst_first_seg", 16'(seg_o), 16'h40);
  endtask

  initial begin
    int n;
    logic found;
    #12;
    check("rst_seg", 16'(seg_o), 16'h7F);
    check("rst_an", 16'(an_o), 16'h7);
    release_reset();

    do_load(2'd1, 4'd2, 4'd3, 1'b0);
    run(30);
    do_load(2'd0, 4'd0, 4'd7, 1'b1);
    run(24);
    do_load(2'd0, 4'd0, 4'd7, 1'b0);
    run(24);
    do_load(2'd1, 4'd2, 4'hC, 1'b0);
    run(24);
    do_load(2'd1, 4'd2, 4'hF, 1'b0);
    run(24);

    // Mid-slot load: park the load on an edge inside the ones ON phase.
    do_load(2'd1, 4'd2, 4'd3, 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 3 * SD) begin
      if ((edge_cnt % SD) == 4 && ((edge_cnt / SD) % 3) == 0) found = 1'b1;
      else begin step(); n++; end
    end
    check("midload_wait", 16'(found), 16'h1);
    check("midload_before", 16'(seg_o), 16'h30);
    do_load(2'd1, 4'd2, 4'd9, 1'b0);
    step();
    check("midload_after", 16'(seg_o), 16'h10);
    run(20);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 3) == 0)
        do_load(2'($urandom_range(0, 1)), 4'($urandom_range(0, 1)),
                4'($urandom_range(0, 9)), 1'b1);
      else
        step();
    end

    // Asynchronous reset during the tens ON phase, well away from any clock edge.
    do_load(2'd1, 4'd2, 4'd3, 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 4 * SD) begin
      step(); n++;
      if (an_o == 3'b101) found = 1'b1;
    end
    check("tens_wait", 16'(found), 16'h1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_seg", 16'(seg_o), 16'h7F);
    check("async_rst_an", 16'(an_o), 16'h7);
    @(posedge clk_i);
    #1;
    check("rst_hold_an", 16'(an_o), 16'h7);
    release_reset();
    run(3 * SD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/bcd_7seg_scan.md
# bcd_7seg_scan

Multiplexed 3-digit seven-segment display driver. Takes the 10-bit BCD triple (hundreds/tens/ones) produced by the binary-to-BCD converter, captures it on a load strobe, and time-multiplexes it onto a shared segment bus with per-digit enables. Sits directly downstream of the BCD converter and drives the board's LED display pins. It provides anti-ghosting gap cycles, optional leading-zero blanking and an error glyph for non-decimal digits.

## Interface

Parameters:

- SCAN_DIV, 50000, clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 500, gap cycles at the start of each slot with all digits off; must be < SCAN_DIV.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0.
- AN_ACTIVE_LOW, 1, 1 = digit enabled when its bit is 0.

Ports:

- clk_i input 1: single clock, rising edge.
- rst_i input 1: reset, asynchronous and active-high.
- load_i input 1: capture ones_i, tens_i, hundreds_i and blank_lz_i on this edge.
- ones_i input 4: BCD ones digit.
- tens_i input 4: BCD tens digit.
- hundreds_i input 2: BCD hundreds digit (0–2 valid; 3 displays as 3).
- blank_lz_i input 1: leading-zero blanking enable; captured with the digits.
- seg_o output 7: segments {g,f,e,d,c,b,a}, registered.
- an_o output 3: digit enables {hundreds,tens,ones}, registered.

## Operation

- Held registers:
  - Capture: h_q (4b, zero-extended from hundreds_i), t_q, o_q and lz_q are captured on every edge with load_i=1.
  - Hold: they hold when load_i=0.
  - Back-to-back loads: each one overwrites the previous capture.
- Slot counter: cnt_q counts 0..SCAN_DIV-1 and wraps to 0.
  - Digit index: idx_q advances on the edge where cnt_q == SCAN_DIV-1.
  - Order: 0 (ones) → 1 (tens) → 2 (hundreds) → 0.
  - idx_q never takes the value 3.
- Per-slot state:
  - GAP while cnt_q < BLANK_CYCLES: all digits off, segments off.
  - ON otherwise: the selected digit is enabled and its glyph is driven.
- Leading-zero blanking (lz_q=1):
  - Hundreds slot is blank if h_q == 0.
  - Tens slot is blank if h_q == 0 and t_q == 0.
  - Ones is never blanked.
  - A blank slot behaves as GAP for the whole slot.
  - Slot timing is unchanged.
- Glyphs (active-high form, {g..a}):
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15: 'E' = 79.
  - If SEG_ACTIVE_LOW=1, the pattern is bitwise inverted.
- Digit enable (active-high form): one-hot 001/010/100 for idx 0/1/2, 000 when off. If AN_ACTIVE_LOW=1, the pattern is inverted.
- At most one an_o bit is active at any time, including across slot boundaries.

## Timing

- Reset (async assert):
  - Immediately: cnt_q=0, idx_q=0, h_q=t_q=o_q=0, lz_q=0.
  - seg_o = all off (7'h7F when active-low, 0 otherwise).
  - an_o = all off (3'b111 when active-low, 000 otherwise).
  - De-assertion is synchronous to clk_i at the RTL boundary.
- Output latency:
  - seg_o/an_o are registered from (cnt_q, idx_q, held registers), so they lag those signals by 1 cycle.
  - After reset release, the k-th rising edge gives cnt_q=k. an_o first enables ones at edge BLANK_CYCLES+1.
- Load latency:
  - Data loaded at edge N appears on seg_o at edge N+1, provided the current slot is ON.
  - Loading does not disturb cnt_q or idx_q.
- Slot period: SCAN_DIV cycles. Full refresh: 3·SCAN_DIV cycles.
- Reset mid-slot: outputs go off asynchronously, and scanning restarts from ones with a full GAP.

## Test plan

Parameters for all scenarios: SCAN_DIV=8, BLANK_CYCLES=2, both polarities active-low.

1. **Reset.** Hold rst_i, then release.
   - During reset: seg_o=7F, an_o=111.
   - an_o stays 111 through edge 2 after release.
   - an_o becomes 110 at edge 3 with seg_o=40 (glyph '0').
2. **Normal digits.** Load h=1, t=2, o=3, lz=0.
   - Ones slot: an_o=110, seg_o=30.
   - Tens slot: an_o=101, seg_o=24.
   - Hundreds slot: an_o=011, seg_o=79.
   - Each slot shows 2 GAP cycles (an_o=111), then 6 ON cycles; the pattern repeats every 24 cycles.
3. **Leading-zero blanking.** Load h=0, t=0, o=7, lz=1.
   - Only the ones slot enables (an_o=110, seg_o=78).
   - Tens and hundreds slots hold an_o=111 for all 8 cycles.
   - Reload with lz=0: tens and hundreds show 40.
4. **Invalid code.** Load o=4'hC.
   - Ones slot: seg_o=06 ('E').
   - o=4'hF gives the same result.
5. **Mid-slot load.** During ON cycle 4 of the ones slot, load o=9 (previously 3).
   - seg_o changes 30→10 on the next edge.
   - an_o and slot boundaries are unchanged.
6. **Mid-scan reset.** Assert rst_i asynchronously during the tens ON phase.
   - seg_o=7F and an_o=111 without waiting for a clock edge.
   - After release, scanning resumes at ones after 2 GAP cycles, and the display shows 0s.
